alu_seq: RTL and testbench

Parametrised, registered successor to the datapath ALU. It accepts one operation per start pulse and returns a registered result with carry, zero and parity flags. It adds multi-cycle operations (iterative multiply, variable shifts) behind a start/ready/done handshake. It sits between the register file read ports and the writeback mux, and the controller stalls on `ready`.

---
 rtl/alu_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered sequential ALU with a start/ready/done handshake and iterative shift/multiply.
// Optional iterative multiplier for op 12 is enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             imm_sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] rslt,
    output logic             sc_o,
    output logic             zero,
    output logic             pari
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_PASSB = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_ADC   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SEQ   = 4'd7;
    localparam logic [3:0] OP_SRL1  = 4'd8;
    localparam logic [3:0] OP_SLL1  = 4'd9;
    localparam logic [3:0] OP_SLLN  = 4'd10;
    localparam logic [3:0] OP_SRLN  = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ITER
    } state_t;

    state_t r_state, w_state_next;

    logic [WIDTH-1:0] r_rslt;
    logic             r_sc;
    logic             r_zero;
    logic             r_pari;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_val;
    logic             r_left;
    logic             r_is_mul;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_shn;
    logic             w_go_iter;
    logic             w_last;
    logic [CW-1:0]    w_n_eff;
    logic [WIDTH-1:0] w_cur_val;
    logic             w_cur_left;
    logic [WIDTH-1:0] w_sh_val;
    logic             w_sh_out;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_one_res;
    logic             w_one_sc;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_wr_res;
    logic             w_wr_sc;
    logic [WIDTH-1:0] w_mul_res;
    logic             w_mul_ovf;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_is_shn = (op == OP_SLLN) || (op == OP_SRLN);
    assign w_last   = (r_state == S_ITER) && (r_cnt == CW'(1));

    // Shift count saturates at WIDTH so oversized amounts just clear the operand.
    always_comb begin
        if (32'(in_b[SHW-1:0]) >= 32'(WIDTH)) begin
            w_n_eff = CW'(WIDTH);
        end else begin
            w_n_eff = CW'(in_b[SHW-1:0]);
        end
    end

    // One shift step; in IDLE it works on the live operand so the accept edge does step one.
    assign w_cur_val  = (r_state == S_IDLE) ? in_a : r_val;
    assign w_cur_left = (r_state == S_IDLE) ? (op == OP_SLLN) : r_left;
    assign w_sh_val   = w_cur_left ? {w_cur_val[WIDTH-2:0], 1'b0} : {1'b0, w_cur_val[WIDTH-1:1]};
    assign w_sh_out   = w_cur_left ? w_cur_val[WIDTH-1] : w_cur_val[0];

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_cur_prod;
    logic [2*WIDTH-1:0] w_cur_mcand;
    logic [WIDTH-1:0]   w_cur_mplier;
    logic [2*WIDTH-1:0] w_prod_next;

    assign w_is_mul     = (op == OP_MUL);
    assign w_cur_prod   = (r_state == S_IDLE) ? '0 : r_prod;
    assign w_cur_mcand  = (r_state == S_IDLE) ? {{WIDTH{1'b0}}, in_a} : r_mcand;
    assign w_cur_mplier = (r_state == S_IDLE) ? in_b : r_mplier;
    assign w_prod_next  = w_cur_mplier[0] ? (w_cur_prod + w_cur_mcand) : w_cur_prod;
    assign w_mul_res    = w_prod_next[WIDTH-1:0];
    assign w_mul_ovf    = |w_prod_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if ((w_accept && w_go_iter) || (r_state == S_ITER)) begin
            r_prod   <= w_prod_next;
            r_mcand  <= {w_cur_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, w_cur_mplier[WIDTH-1:1]};
        end
    end
`else
    assign w_is_mul  = 1'b0;
    assign w_mul_res = '0;
    assign w_mul_ovf = 1'b0;
`endif

    assign w_go_iter = !imm_sel && ((w_is_shn && (w_n_eff > CW'(1))) || w_is_mul);

    always_comb begin
        w_one_res = '0;
        w_one_sc  = 1'b0;
        w_sum     = '0;
        case (op)
            OP_PASSB: w_one_res = in_b;
            OP_ADD: begin
                w_sum     = {1'b0, in_a} + {1'b0, in_b};
                w_one_res = w_sum[WIDTH-1:0];
                w_one_sc  = w_sum[WIDTH];
            end
            OP_ADC: begin
                w_sum     = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, r_sc};
                w_one_res = w_sum[WIDTH-1:0];
                w_one_sc  = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_one_res = in_a - in_b;
                w_one_sc  = (in_a < in_b);
            end
            OP_AND:  w_one_res = in_a & in_b;
            OP_OR:   w_one_res = in_a | in_b;
            OP_XOR:  w_one_res = in_a ^ in_b;
            OP_SEQ:  w_one_res = (in_a == in_b) ? WIDTH'(1) : '0;
            OP_SRL1: begin
                w_one_res = {r_sc, in_a[WIDTH-1:1]};
                w_one_sc  = in_a[0];
            end
            OP_SLL1: begin
                w_one_res = {in_a[WIDTH-2:0], r_sc};
                w_one_sc  = in_a[WIDTH-1];
            end
            // Only n of 0 or 1 reaches here; longer shifts take the iterative path.
            OP_SLLN, OP_SRLN: begin
                if (w_n_eff == '0) begin
                    w_one_res = in_a;
                end else begin
                    w_one_res = w_sh_val;
                    w_one_sc  = w_sh_out;
                end
            end
            default: begin
                w_one_res = '0;
                w_one_sc  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_wr_en  = (w_accept && !w_go_iter) || w_last;
        w_wr_res = w_one_res;
        w_wr_sc  = w_one_sc;
        if (r_state == S_ITER) begin
            w_wr_res = r_is_mul ? w_mul_res : w_sh_val;
            w_wr_sc  = r_is_mul ? w_mul_ovf : w_sh_out;
        end else if (imm_sel) begin
            w_wr_res = in_b;
            w_wr_sc  = r_sc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = w_go_iter ? S_ITER : S_EXEC;
                end
            end
            S_EXEC: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            S_ITER: begin
                if (w_last) begin
                    w_state_next = S_EXEC;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rslt   <= '0;
            r_sc     <= 1'b0;
            r_zero   <= 1'b1;
            r_pari   <= 1'b0;
            r_cnt    <= '0;
            r_val    <= '0;
            r_left   <= 1'b0;
            r_is_mul <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_rslt <= w_wr_res;
                r_sc   <= w_wr_sc;
                r_zero <= (w_wr_res == '0);
                r_pari <= ^w_wr_res;
            end
            // The accept edge already performs the first step, so count the remaining ones.
            if (w_accept && w_go_iter) begin
                r_cnt    <= w_is_mul ? CW'(WIDTH - 1) : (w_n_eff - CW'(1));
                r_val    <= w_sh_val;
                r_left   <= (op == OP_SLLN);
                r_is_mul <= w_is_mul;
            end else if (r_state == S_ITER) begin
                r_cnt <= r_cnt - CW'(1);
                r_val <= w_sh_val;
            end
        end
    end

    assign rslt = r_rslt;
    assign sc_o = r_sc;
    assign zero = r_zero;
    assign pari = r_pari;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq (WIDTH=8); expectations adapt to ALU_SEQ_MUL_EN.
module tb_alu_seq;

    localparam int W   = 8;
    localparam int SHW = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [3:0]   op;
    logic         imm_sel;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         ready;
    logic         done;
    logic [W-1:0] rslt;
    logic         sc_o;
    logic         zero;
    logic         pari;

    int n_checks = 0;
    int n_errors = 0;
    logic model_sc = 1'b0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         sc;
        logic         z;
        logic         p;
        logic [7:0]   lat;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(W), .SHW(SHW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .imm_sel(imm_sel),
        .in_a(in_a), .in_b(in_b), .ready(ready), .done(done), .rslt(rslt),
        .sc_o(sc_o), .zero(zero), .pari(pari)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic im, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic sci);
        exp_t        e;
        logic [W:0]  s;
        logic [15:0] p;
        int          n;
        int          k;
        e.r   = '0;
        e.sc  = 1'b0;
        e.lat = 8'd1;
        s     = '0;
        p     = '0;
        if (im) begin
            e.r  = b;
            e.sc = sci;
        end else begin
            case (o)
                4'd0: e.r = b;
                4'd1: begin s = {1'b0, a} + {1'b0, b}; e.r = s[W-1:0]; e.sc = s[W]; end
                4'd2: begin s = {1'b0, a} + {1'b0, b} + {8'd0, sci}; e.r = s[W-1:0]; e.sc = s[W]; end
                4'd3: begin e.r = a - b; e.sc = (a < b); end
                4'd4: e.r = a & b;
                4'd5: e.r = a | b;
                4'd6: e.r = a ^ b;
                4'd7: e.r = (a == b) ? 8'd1 : 8'd0;
                4'd8: begin e.r = {sci, a[W-1:1]}; e.sc = a[0]; end
                4'd9: begin e.r = {a[W-2:0], sci}; e.sc = a[W-1]; end
                4'd10, 4'd11: begin
                    n = int'(b[SHW-1:0]);
                    k = (n > W) ? W : n;
                    e.lat = (k == 0) ? 8'd1 : 8'(k);
                    if (k == 0) e.r = a;
                    else if (o == 4'd10) begin
                        e.r  = (k >= W) ? 8'd0 : 8'(a << k);
                        e.sc = a[W-k];
                    end else begin
                        e.r  = (k >= W) ? 8'd0 : 8'(a >> k);
                        e.sc = a[k-1];
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                4'd12: begin
                    p = {8'd0, a} * {8'd0, b};
                    e.r = p[W-1:0]; e.sc = |p[15:W]; e.lat = 8'(W);
                end
`endif
                default: ;
            endcase
        end
        e.z = (e.r == '0);
        e.p = ^e.r;
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op_v, input logic imm_v,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit mid_start);
        exp_t e;
        exp_t ex;
        int   lat;
        bit   seen;
        lat = 0;
        while (!ready && lat < 50) begin @(negedge clk); lat++; end
        check({tag, "_ready_wait"}, 32'(ready), 32'd1);
        e = model(op_v, imm_v, a, b, model_sc);
        model_sc = e.sc;
        sb.push_back(e);
        start = 1'b1; op = op_v; imm_sel = imm_v; in_a = a; in_b = b;
        @(posedge clk); #1;
        start = 1'b0; imm_sel = 1'b0; op = 4'($urandom); in_a = ~a; in_b = b ^ 8'h5A;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, "_ready_low"}, 32'(ready), 32'd0);
            if (mid_start && lat == 2) begin start = 1'b1; op = 4'd1; in_a = 8'h11; in_b = 8'h22; end
            if (mid_start && lat == 3) start = 1'b0;
            seen = done;
        end
        start = 1'b0;
        ex = sb.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(ex.lat));
        check({tag, "_rslt"}, 32'(rslt), 32'(ex.r));
        check({tag, "_sc"}, 32'(sc_o), 32'(ex.sc));
        check({tag, "_zero"}, 32'(zero), 32'(ex.z));
        check({tag, "_pari"}, 32'(pari), 32'(ex.p));
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'd0, done, ready}, 32'd1);
        check({tag, "_hold"}, 32'(rslt), 32'(ex.r));
        $display("op %-10s a=%02h b=%02h -> rslt=%02h sc=%0b z=%0b p=%0b lat=%0d",
                 tag, a, b, rslt, sc_o, zero, pari, lat);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rslt"}, 32'(rslt), 32'd0);
        check({tag, "_flags"}, {28'd0, sc_o, zero, pari, done}, 32'b0100);
        check({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int  lat;
        bit  saw_done;
        reset_n = 1'b0; start = 1'b1; op = 4'd1; imm_sel = 1'b0; in_a = 8'hFF; in_b = 8'hFF;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_start_ignored", {31'd0, done}, 32'd0);
        $display("reset released: rslt=%02h zero=%0b ready=%0b", rslt, zero, ready);

        run_op("ADD",   4'd1,  1'b0, 8'hF0, 8'h20, 1'b0);
        run_op("ADC",   4'd2,  1'b0, 8'h01, 8'h01, 1'b0);
        run_op("SUB",   4'd3,  1'b0, 8'h05, 8'h07, 1'b0);
        run_op("SRL1",  4'd8,  1'b0, 8'h02, 8'h00, 1'b0);
        run_op("SEQ_EQ", 4'd7, 1'b0, 8'h5A, 8'h5A, 1'b0);
        run_op("SEQ_NE", 4'd7, 1'b0, 8'h5A, 8'h5B, 1'b0);
        run_op("SLL1",  4'd9,  1'b0, 8'h81, 8'h00, 1'b0);
        run_op("ADC_C", 4'd2,  1'b0, 8'h10, 8'h20, 1'b0);
        run_op("AND",   4'd4,  1'b0, 8'hCC, 8'hAA, 1'b0);
        run_op("OR",    4'd5,  1'b0, 8'hC0, 8'h0A, 1'b0);
        run_op("XOR",   4'd6,  1'b0, 8'hFF, 8'hFF, 1'b0);
        run_op("PASSB", 4'd0,  1'b0, 8'h12, 8'h37, 1'b0);
        run_op("ILLEGAL", 4'd14, 1'b0, 8'h12, 8'h34, 1'b0);
        run_op("MUL_13x11", 4'd12, 1'b0, 8'd13, 8'd11, 1'b0);
        run_op("MUL_20x20", 4'd12, 1'b0, 8'd20, 8'd20, 1'b1);
        run_op("SLLN_3", 4'd10, 1'b0, 8'h03, 8'h03, 1'b0);
        run_op("SRLN_9", 4'd11, 1'b0, 8'h81, 8'h09, 1'b1);
        run_op("SLLN_0", 4'd10, 1'b0, 8'hA5, 8'h00, 1'b0);
        run_op("SRLN_1", 4'd11, 1'b0, 8'hA5, 8'h01, 1'b0);
        run_op("SLLN_15", 4'd10, 1'b0, 8'hA5, 8'h0F, 1'b0);
        run_op("SRLN_5", 4'd11, 1'b0, 8'hF0, 8'h05, 1'b0);
        run_op("SUB_B", 4'd3,  1'b0, 8'h00, 8'h01, 1'b0);
        run_op("IMM_80", 4'd3, 1'b1, 8'h00, 8'h80, 1'b0);

        // Abort a long iterative op with reset four cycles after accept.
        start = 1'b1; imm_sel = 1'b0; in_a = 8'h0D; in_b = 8'h07;
`ifdef ALU_SEQ_MUL_EN
        op = 4'd12;
`else
        op = 4'd10;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        saw_done = 1'b0;
        for (lat = 1; lat <= 4; lat++) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_mid_iter");
        reset_n = 1'b1;
        model_sc = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        check("reset_mid_iter_no_done", {31'd0, saw_done}, 32'd0);
        $display("op ABORT     reset mid-iteration: rslt=%02h sc=%0b done_seen=%0b", rslt, sc_o, saw_done);

        run_op("IMM_00", 4'd1, 1'b1, 8'hFF, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
